dual_bram_arbiter: RTL and testbench
====================================

Name: dual_bram_arbiter

Overview:
- Controller in front of one dual-port block RAM: one write port, one read-through read port.
- After reset, sequences a zero-fill of the whole RAM.
- Then shares the write port between two write requesters and the read port between two read requesters, each with an independent round-robin arbiter.
- Drives the RAM's enable/wen/waddr/raddr/din; returns read data tagged to the requester with fixed 1-cycle latency.

Parameters:
- WIDTH, 36, data word width; must match the RAM instance.
- LOG_DEP, 6, address width; RAM depth DEPTH = 1 << LOG_DEP.

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_req  in  2  bit k: write requester k requests
- wr_addr  in  2*LOG_DEP  requester k address at bits [k*LOG_DEP +: LOG_DEP]
- wr_data  in  2*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
- wr_ack  out  2  one-hot grant; write commits at this clock edge
- rd_req  in  2  bit k: read requester k requests
- rd_addr  in  2*LOG_DEP  packed as wr_addr
- rd_ack  out  2  one-hot read grant
- rd_valid  out  2  one-hot; rd_data is valid for requester k this cycle
- rd_data  out  WIDTH  read return data (equals bram_dout)
- init_done  out  1  high once zero-fill is complete
- bram_enable  out  1  RAM enable
- bram_wen  out  1  RAM write enable
- bram_waddr  out  LOG_DEP  RAM write address
- bram_raddr  out  LOG_DEP  RAM read address
- bram_din  out  WIDTH  RAM write data
- bram_dout  in  WIDTH  RAM read data (from registered read address)

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values:
  - state = INIT, init counter = 0, both round-robin pointers = 0 (requester 0 favoured).
  - rd_valid = 0, init_done = 0.
  - wr_ack / rd_ack = 0 while in INIT.
- FSM states: INIT and RUN.
- INIT:
  - bram_enable = 1, bram_wen = 1, bram_waddr = counter, bram_din = 0, bram_raddr = 0.
  - Counter increments each cycle.
  - When counter == DEPTH-1, the next state is RUN.
  - INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - All requests are ignored (acks 0).
- RUN:
  - init_done = 1 and stays 1 until the next reset.
  - Write arbiter (combinational grant):
    - One requester active: grant it.
    - Both active: grant the requester the pointer favours.
    - The pointer moves to the other requester after any cycle in which both requested.
    - A lone request does not move the pointer.
  - Read arbiter: identical rules, with its own pointer.
  - wr_ack/rd_ack are asserted in the same cycle as the grant, combinational from req and pointer.
  - A requester holds req, addr and data stable until it sees ack; it may drop req in the cycle after ack or re-request back-to-back.
- RAM drive in RUN:
  - bram_wen = |wr_ack; bram_waddr and bram_din are muxed from the granted write requester.
  - bram_raddr is muxed from the granted read requester; it holds its last value when no read is granted.
  - bram_enable = |wr_ack or |rd_ack.
- Read latency:
  - rd_valid[k] is a register equal to rd_ack[k] delayed one cycle.
  - rd_data = bram_dout, combinational.
  - Throughput is one read and one write per cycle.
- Same-address collision: a write and a read to the same address granted in the same cycle return the NEW data (write-first, as the RAM's read-through provides). No bypass logic is added.
- Idle cycles: bram_enable = 0, so the RAM holds its registered read address and bram_dout stays stable; rd_valid is 0.
- Reset mid-operation:
  - Any in-flight read response is dropped (rd_valid = 0 the next cycle).
  - The FSM re-enters INIT and re-zeroes the RAM.

Optional Feature:
- Macro: DUAL_BRAM_ARB_STATS_EN.
- Defined:
  - Adds output wr_stall_cnt (16 bits): saturating count of RUN cycles in which a write requester had req=1 and ack=0.
  - Adds output rd_stall_cnt (16 bits): the same count for read requesters.
  - A cycle where both requesters of a port stall counts 2.
  - Counters clear on reset and hold at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle:
  - init_done rises after exactly 64 cycles (LOG_DEP=6).
  - During INIT, bram_waddr steps 0..63 with bram_din=0.
  - A later read of address 17 returns 0.
- Single write then read:
  - wr_req[0] with addr 5, data 36'h123456789: wr_ack[0] in the same cycle.
  - rd_req[1] with addr 5 next cycle: rd_ack[1] that cycle, then rd_valid[1]=1 with rd_data=36'h123456789 one cycle later.
- Contention:
  - wr_req=2'b11 held for 4 cycles: wr_ack sequence 01,10,01,10.
  - Same test on rd_req: rd_ack alternates likewise; rd_valid follows one cycle later.
- Collision:
  - addr 9 holds 36'hA; in the same RUN cycle, write addr 9 = 36'hB and read addr 9.
  - Next cycle rd_data = 36'hB.
- Requests during INIT:
  - wr_req=2'b01 and rd_req=2'b10 asserted from reset: no acks until init_done.
  - First RUN cycle acks both.
- Reset mid-read:
  - reset asserted in the cycle of rd_ack[0]: rd_valid stays 0 and init_done drops to 0.
  - With DUAL_BRAM_ARB_STATS_EN, the 4-cycle contention test gives wr_stall_cnt=4.

Source files
------------

// File: rtl/dual_bram_arbiter.sv
// Front end for one dual-port BRAM: zero-fills the RAM after reset, then round-robin
// arbitrates two writers and two readers. Define DUAL_BRAM_ARB_STATS_EN for stall counters.

module dual_bram_arbiter_rr (
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Favour flips only after a contended cycle; a lone request leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && (req_i == 2'b11)) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// state  | meaning
// S_INIT | zero-filling the RAM, one word per cycle, requests ignored
// S_RUN  | arbitrating requesters onto the RAM ports
module dual_bram_arbiter #(
  parameter int WIDTH   = 36,
  parameter int LOG_DEP = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             wr_req,
  input  logic [2*LOG_DEP-1:0]   wr_addr,
  input  logic [2*WIDTH-1:0]     wr_data,
  output logic [1:0]             wr_ack,
  input  logic [1:0]             rd_req,
  input  logic [2*LOG_DEP-1:0]   rd_addr,
  output logic [1:0]             rd_ack,
  output logic [1:0]             rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   init_done,
  output logic                   bram_enable,
  output logic                   bram_wen,
  output logic [LOG_DEP-1:0]     bram_waddr,
  output logic [LOG_DEP-1:0]     bram_raddr,
  output logic [WIDTH-1:0]       bram_din,
`ifdef DUAL_BRAM_ARB_STATS_EN
  output logic [15:0]            wr_stall_cnt,
  output logic [15:0]            rd_stall_cnt,
`endif
  input  logic [WIDTH-1:0]       bram_dout
);

  localparam logic [LOG_DEP-1:0] LAST_ADDR = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [LOG_DEP-1:0]   cnt_q, cnt_d;
  logic [LOG_DEP-1:0]   raddr_q;
  logic [1:0]           rd_valid_q;
  logic                 run;
  logic [LOG_DEP-1:0]   wr_addr_sel, rd_addr_sel;
  logic [WIDTH-1:0]     wr_data_sel;

  assign run = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  dual_bram_arbiter_rr u_wr_arb (
    .clock (clock),
    .reset (reset),
    .en_i  (run),
    .req_i (wr_req),
    .gnt_o (wr_ack)
  );

  dual_bram_arbiter_rr u_rd_arb (
    .clock (clock),
    .reset (reset),
    .en_i  (run),
    .req_i (rd_req),
    .gnt_o (rd_ack)
  );

  assign wr_addr_sel = wr_ack[1] ? wr_addr[LOG_DEP +: LOG_DEP] : wr_addr[0 +: LOG_DEP];
  assign wr_data_sel = wr_ack[1] ? wr_data[WIDTH +: WIDTH]     : wr_data[0 +: WIDTH];
  assign rd_addr_sel = rd_ack[1] ? rd_addr[LOG_DEP +: LOG_DEP] : rd_addr[0 +: LOG_DEP];

  always_comb begin
    bram_enable = 1'b1;
    bram_wen    = 1'b1;
    bram_waddr  = cnt_q;
    bram_din    = '0;
    bram_raddr  = '0;
    if (run) begin
      bram_wen    = |wr_ack;
      bram_waddr  = wr_addr_sel;
      bram_din    = wr_data_sel;
      // With no read granted the RAM is either disabled or only writing, so keep the old address.
      bram_raddr  = (|rd_ack) ? rd_addr_sel : raddr_q;
      bram_enable = (|wr_ack) | (|rd_ack);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      raddr_q    <= '0;
      rd_valid_q <= 2'b00;
    end else begin
      raddr_q    <= bram_raddr;
      rd_valid_q <= rd_ack;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = bram_dout;
  assign init_done = run;

`ifdef DUAL_BRAM_ARB_STATS_EN
  logic [15:0] wr_stall_q, rd_stall_q;
  logic [1:0]  wr_stall_bits, rd_stall_bits;
  logic [16:0] wr_stall_sum, rd_stall_sum;

  assign wr_stall_bits = run ? (wr_req & ~wr_ack) : 2'b00;
  assign rd_stall_bits = run ? (rd_req & ~rd_ack) : 2'b00;
  assign wr_stall_sum  = {1'b0, wr_stall_q} + 17'(wr_stall_bits[0]) + 17'(wr_stall_bits[1]);
  assign rd_stall_sum  = {1'b0, rd_stall_q} + 17'(rd_stall_bits[0]) + 17'(rd_stall_bits[1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      wr_stall_q <= wr_stall_sum[16] ? 16'hFFFF : wr_stall_sum[15:0];
      rd_stall_q <= rd_stall_sum[16] ? 16'hFFFF : rd_stall_sum[15:0];
    end
  end

  assign wr_stall_cnt = wr_stall_q;
  assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_dual_bram_arbiter.sv
// Bench for dual_bram_arbiter: behavioural RAM, per-cycle reference model and directed tests.
// Honours DUAL_BRAM_ARB_STATS_EN when the design is built with it.

module tb_dual_bram_arbiter;

  localparam int W     = 36;
  localparam int LD    = 6;
  localparam int DEPTH = 1 << LD;

  logic            clock, reset;
  logic [1:0]      wr_req, wr_ack, rd_req, rd_ack, rd_valid;
  logic [2*LD-1:0] wr_addr, rd_addr;
  logic [2*W-1:0]  wr_data;
  logic [W-1:0]    rd_data, bram_din, bram_dout;
  logic            init_done, bram_enable, bram_wen;
  logic [LD-1:0]   bram_waddr, bram_raddr;
`ifdef DUAL_BRAM_ARB_STATS_EN
  logic [15:0]     wr_stall_cnt, rd_stall_cnt;
`endif

  dual_bram_arbiter #(.WIDTH(W), .LOG_DEP(LD)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .init_done   (init_done),
    .bram_enable (bram_enable),
    .bram_wen    (bram_wen),
    .bram_waddr  (bram_waddr),
    .bram_raddr  (bram_raddr),
    .bram_din    (bram_din),
`ifdef DUAL_BRAM_ARB_STATS_EN
    .wr_stall_cnt(wr_stall_cnt),
    .rd_stall_cnt(rd_stall_cnt),
`endif
    .bram_dout   (bram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first RAM with registered read address, as the real block RAM behaves.
  logic [W-1:0]  ram [DEPTH];
  logic [LD-1:0] ram_raddr_q;
  always @(posedge clock) begin
    if (bram_enable) begin
      if (bram_wen) ram[bram_waddr] <= bram_din;
      ram_raddr_q <= bram_raddr;
    end
  end
  assign bram_dout = ram[ram_raddr_q];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] grant(input logic [1:0] r, input int fav);
    if (r == 2'b11) return (fav == 0) ? 2'b01 : 2'b10;
    return r;
  endfunction

  function automatic int popc(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  // Reference model: state advanced once per cycle from the inputs seen at the falling edge.
  bit           m_known = 0;
  int           m_since = 0;
  int           m_wfav = 0, m_rfav = 0;
  logic [1:0]   m_rdv = 2'b00;
  logic [W-1:0] m_rdata = '0;
  int           m_last_ra = 0;
  logic [W-1:0] shadow [DEPTH];
  int           m_wst = 0, m_rst = 0;

  always @(negedge clock) begin : model
    bit         run;
    logic [1:0] ewa, era;
    int         wk, rk, wa, ra;
    logic [W-1:0] wd;
    run = (m_since >= DEPTH);
    ewa = run ? grant(wr_req, m_wfav) : 2'b00;
    era = run ? grant(rd_req, m_rfav) : 2'b00;
    wk  = ewa[1] ? 1 : 0;
    rk  = era[1] ? 1 : 0;
    wa  = int'(wr_addr[wk*LD +: LD]);
    wd  = wr_data[wk*W +: W];
    ra  = int'(rd_addr[rk*LD +: LD]);
    if (m_known) begin
      chk("init_done", 64'(init_done), 64'(run));
      chk("wr_ack", 64'(wr_ack), 64'(ewa));
      chk("rd_ack", 64'(rd_ack), 64'(era));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      if (m_rdv != 2'b00) chk("rd_data", 64'(rd_data), 64'(m_rdata));
      if (!run) begin
        chk("init_enable", 64'(bram_enable), 64'd1);
        chk("init_wen", 64'(bram_wen), 64'd1);
        chk("init_waddr", 64'(bram_waddr), 64'(m_since));
        chk("init_din", 64'(bram_din), 64'd0);
        chk("init_raddr", 64'(bram_raddr), 64'd0);
      end else begin
        chk("enable", 64'(bram_enable), 64'((ewa != 0) || (era != 0)));
        chk("wen", 64'(bram_wen), 64'(ewa != 0));
        if (ewa != 0) begin
          chk("waddr", 64'(bram_waddr), 64'(wa));
          chk("din", 64'(bram_din), 64'(wd));
        end
        chk("raddr", 64'(bram_raddr), 64'((era != 0) ? ra : m_last_ra));
      end
`ifdef DUAL_BRAM_ARB_STATS_EN
      chk("wr_stall_cnt", 64'(wr_stall_cnt), 64'(m_wst));
      chk("rd_stall_cnt", 64'(rd_stall_cnt), 64'(m_rst));
`endif
    end
    if (reset) begin
      m_known = 1; m_since = 0; m_wfav = 0; m_rfav = 0;
      m_rdv = 2'b00; m_last_ra = 0; m_wst = 0; m_rst = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    end else if (m_known) begin
      if (!run) begin
        m_since++;
        m_rdv = 2'b00;
      end else begin
        if (ewa != 0) shadow[wa] = wd;
        if (era != 0) begin
          m_rdata   = shadow[ra];
          m_last_ra = ra;
        end
        m_rdv = era;
        if (wr_req == 2'b11) m_wfav = 1 - m_wfav;
        if (rd_req == 2'b11) m_rfav = 1 - m_rfav;
        m_wst = m_wst + popc(wr_req & ~ewa);
        m_rst = m_rst + popc(rd_req & ~era);
        if (m_wst > 65535) m_wst = 65535;
        if (m_rst > 65535) m_rst = 65535;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin : stim
    int n;
`ifdef DUAL_BRAM_ARB_STATS_EN
    logic [15:0] st0;
`endif
    reset = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    step(); step();
    reset = 1'b0;
    wait_init(n);
    chk("init_cycles", 64'(n), 64'd64);

    // zero-filled word
    rd_req = 2'b01; rd_addr[0 +: LD] = 6'd17;
    step();
    rd_req = 2'b00;
    chk("rd17_valid", 64'(rd_valid), 64'h1);
    chk("rd17_data", 64'(rd_data), 64'h0);

    // single write then read back
    wr_req = 2'b01; wr_addr[0 +: LD] = 6'd5; wr_data[0 +: W] = 36'h123456789;
    #1 chk("wr5_ack", 64'(wr_ack), 64'h1);
    step();
    wr_req = 2'b00;
    rd_req = 2'b10; rd_addr[LD +: LD] = 6'd5;
    #1 chk("rd5_ack", 64'(rd_ack), 64'h2);
    step();
    rd_req = 2'b00;
    chk("rd5_valid", 64'(rd_valid), 64'h2);
    chk("rd5_data", 64'(rd_data), 64'h123456789);

    // write contention
`ifdef DUAL_BRAM_ARB_STATS_EN
    st0 = wr_stall_cnt;
`endif
    wr_req = 2'b11;
    wr_addr = {6'd21, 6'd20};
    wr_data = {36'h0000BBBB2, 36'h0000AAAA1};
    for (int i = 0; i < 4; i++) begin
      #1 chk("wr_contend", 64'(wr_ack), (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
    end
    wr_req = 2'b00;
`ifdef DUAL_BRAM_ARB_STATS_EN
    chk("wr_stall_delta", 64'(wr_stall_cnt - st0), 64'd4);
`endif

    // read contention
    rd_req = 2'b11;
    rd_addr = {6'd21, 6'd20};
    for (int i = 0; i < 4; i++) begin
      #1 chk("rd_contend", 64'(rd_ack), (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
      chk("rd_contend_valid", 64'(rd_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    rd_req = 2'b00;

    // same-address collision returns new data
    wr_req = 2'b01; wr_addr[0 +: LD] = 6'd9; wr_data[0 +: W] = 36'hA;
    step();
    wr_data[0 +: W] = 36'hB;
    rd_req = 2'b01; rd_addr[0 +: LD] = 6'd9;
    step();
    wr_req = 2'b00; rd_req = 2'b00;
    chk("collide_valid", 64'(rd_valid), 64'h1);
    chk("collide_data", 64'(rd_data), 64'hB);

    // requests held through reset and INIT
    reset = 1'b1;
    wr_req = 2'b01; wr_addr[0 +: LD] = 6'd30; wr_data[0 +: W] = 36'h77;
    rd_req = 2'b10; rd_addr[LD +: LD] = 6'd9;
    step(); step();
    reset = 1'b0;
    wait_init(n);
    chk("reinit_cycles", 64'(n), 64'd64);
    #1 chk("first_run_wr_ack", 64'(wr_ack), 64'h1);
    chk("first_run_rd_ack", 64'(rd_ack), 64'h2);
    step();
    wr_req = 2'b00; rd_req = 2'b00;
    chk("rezero_valid", 64'(rd_valid), 64'h2);
    chk("rezero_data", 64'(rd_data), 64'h0);

    // reset lands on a read grant
    rd_req = 2'b01; rd_addr[0 +: LD] = 6'd30; reset = 1'b1;
    #1 chk("midrd_ack", 64'(rd_ack), 64'h1);
    step();
    rd_req = 2'b00;
    chk("midrd_valid", 64'(rd_valid), 64'h0);
    chk("midrd_init_done", 64'(init_done), 64'h0);
    reset = 1'b0;
    wait_init(n);
    chk("final_init_cycles", 64'(n), 64'd64);
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
